// File: rtl/mux_nx1_arb.sv
// N-to-1 registered multiplexer with valid/ready handshake on every channel.
// The grant comes from fixed priority, round-robin or manual select, chosen by MODE.
module mux_nx1_arb #(
   parameter  int W    = 8,
   parameter  int N    = 4,
   parameter  int MODE = 1,
   localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SW-1:0]  out_sel
);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_sel_q, out_sel_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic [N-1:0]  gnt;
   logic          load_en;
   logic          xfer;
   logic [W-1:0]  pick_data;
   logic [SW-1:0] pick_idx;

   assign load_en  = !out_valid_q || out_ready;
   assign in_ready = gnt & {N{load_en & rst_n}};
   assign xfer     = |in_ready;

   always_comb begin
      logic found;
      int   pos;
      gnt   = '0;
      found = 1'b0;
      pos   = 0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && !found) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end else if (MODE == 1) begin
         // Search order starts at ptr and wraps past N-1 back to 0.
         for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) pos = pos - N;
            for (int i = 0; i < N; i++) begin
               if (!found && (pos == i) && in_valid[i]) begin
                  gnt[i] = 1'b1;
                  found  = 1'b1;
               end
            end
         end
      end else begin
         // A select beyond N-1 matches no channel, so nothing is granted.
         for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) gnt[i] = in_valid[i];
         end
      end
   end

   always_comb begin
      pick_data = '0;
      pick_idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            pick_data = in_data[i*W +: W];
            pick_idx  = SW'(i);
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = pick_data;
         out_sel_d   = pick_idx;
         out_valid_d = 1'b1;
         if (MODE == 1) begin
            ptr_d = (pick_idx == SW'(N - 1)) ? '0 : pick_idx + 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule
